// File: rtl/dec_reader_if.sv
// Byte-in / word-out handshake bundle for dec_reader.
// slave is the converter side, master is the UART/core side driving it.
interface dec_reader_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;

  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, out_err);
  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, out_err);
endinterface

// File: rtl/dec_reader.sv
// Streaming ASCII decimal to 32-bit binary converter, one result per token.
// Define SIGNED_EN to accept a leading '-' and produce two's complement results.
module dec_reader (
  input  logic        clk,
  input  logic        rstn,
  dec_reader_if.slave bus
);
  typedef enum logic [1:0] {SKIP, SIGN, DIGIT, OUT} state_t;

  state_t      state;
  logic [31:0] acc;
  logic        ovf;
  logic        out_valid_q, out_err_q;
  logic [31:0] out_data_q;
  logic        is_ws, is_dig, fire;
  logic [3:0]  dval;
  logic [35:0] nxt;
  logic [31:0] res_data;
  logic        res_err;

  assign is_ws  = (bus.in_data == 8'h20) || (bus.in_data == 8'h09) ||
                  (bus.in_data == 8'h0A) || (bus.in_data == 8'h0D);
  assign is_dig = (bus.in_data >= 8'h30) && (bus.in_data <= 8'h39);
  assign dval   = bus.in_data[3:0];
  // acc*10 + d on a 36-bit path so the carry out tells us about overflow
  assign nxt    = ({4'b0, acc} << 3) + ({4'b0, acc} << 1) + {32'b0, dval};
  assign fire   = bus.in_valid && bus.in_ready;

  assign bus.in_ready  = (state != OUT);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_err   = out_err_q;

`ifdef SIGNED_EN
  logic neg;
  // magnitude limit is 2^31 for negatives, 2^31-1 for positives
  assign res_data = neg ? (~acc + 32'd1) : acc;
  assign res_err  = ovf | (neg ? (acc > 32'h8000_0000) : acc[31]);
`else
  assign res_data = acc;
  assign res_err  = ovf;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= SKIP;
      acc         <= 32'd0;
      ovf         <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
      out_err_q   <= 1'b0;
`ifdef SIGNED_EN
      neg         <= 1'b0;
`endif
    end else begin
      case (state)
        SKIP: if (fire) begin
          if (is_dig) begin
            acc   <= {28'd0, dval};
            ovf   <= 1'b0;
`ifdef SIGNED_EN
            neg   <= 1'b0;
`endif
            state <= DIGIT;
`ifdef SIGNED_EN
          end else if (bus.in_data == 8'h2D) begin
            neg   <= 1'b1;
            acc   <= 32'd0;
            ovf   <= 1'b0;
            state <= SIGN;
`endif
          end else if (!is_ws) begin
            out_data_q  <= 32'd0;
            out_err_q   <= 1'b1;
            out_valid_q <= 1'b1;
            state       <= OUT;
          end
        end
`ifdef SIGNED_EN
        SIGN: if (fire) begin
          if (is_dig) begin
            acc   <= {28'd0, dval};
            state <= DIGIT;
          end else begin
            out_data_q  <= 32'd0;
            out_err_q   <= 1'b1;
            out_valid_q <= 1'b1;
            state       <= OUT;
          end
        end
`endif
        DIGIT: if (fire) begin
          if (is_dig) begin
            acc <= nxt[31:0];
            ovf <= ovf | (|nxt[35:32]);
          end else begin
            // terminator is swallowed here, never reparsed in SKIP
            out_data_q  <= res_data;
            out_err_q   <= res_err;
            out_valid_q <= 1'b1;
            state       <= OUT;
          end
        end
        OUT: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          state       <= SKIP;
        end
        default: state <= SKIP;
      endcase
    end
  end
endmodule

// File: doc/dec_reader.md
# dec_reader

Streaming ASCII decimal-to-binary converter placed between the UART receive byte stream and the core's input port. It skips whitespace and accumulates digit characters with a shift-add ×10 step, acc·10 = (acc<<3) + (acc<<1). It emits one 32-bit integer per token over a valid/ready handshake. This gives the core a hardware decimal-input path alongside its ×10/÷10 helpers.

## Interface
- No parameters.
- clk  in  1  clock; all state on rising edge
- rstn  in  1  reset, asynchronous, active-low
- in_valid  in  1  byte available from UART receiver
- in_ready  out  1  block accepts byte this cycle
- in_data  in  8  ASCII byte
- out_valid  out  1  token result available
- out_ready  in  1  consumer takes result this cycle
- out_data  out  32  parsed value; two's complement when signed
- out_err  out  1  token malformed or out of range; qualifies out_data

## Operation
- A byte is consumed when in_valid && in_ready. A result is taken when out_valid && out_ready.
- Whitespace is 0x20, 0x09, 0x0A, 0x0D. Digits are 0x30–0x39.
- FSM states: SKIP, SIGN, DIGIT, OUT. The reset state is SKIP.
- SKIP:
  - Whitespace: discard and stay in SKIP.
  - Digit d: acc←d, ovf←0, neg←0, go to DIGIT.
  - '-' (only with SIGNED_EN): neg←1, acc←0, go to SIGN.
  - Any other byte: consume it, load result 0 with err=1, go to OUT.
- SIGN:
  - Digit d: acc←d, go to DIGIT.
  - Any other byte: consume it, load result 0 with err=1, go to OUT.
- DIGIT:
  - Digit d: acc←(acc·10 + d) mod 2^32.
    - Overflow is computed on a 36-bit intermediate.
    - ovf←ovf | (intermediate ≥ 2^32).
  - Any non-digit byte is the terminator. It is consumed, not reparsed.
    - Unsigned result: out_data←acc, out_err←ovf.
    - Then go to OUT.
- OUT:
  - in_ready=0.
  - out_valid=1; out_data and out_err are held stable.
  - When out_ready is seen, go to SKIP.
- in_ready = 1 in SKIP, SIGN and DIGIT regardless of out_ready.
- Wrap-around: on overflow, out_data is the low 32 bits of the true value, with out_err=1.

## Timing
- Reset values:
  - state=SKIP, acc=0, ovf=0, neg=0.
  - out_valid=0, out_data=0, out_err=0.
  - in_ready=1 (combinational from state).
- Reset asserted mid-token discards the partial accumulation. An unconsumed OUT result is also lost.
- Latency: if the terminator or invalid byte is accepted on edge N, out_valid is high from after edge N. The result is taken at the earliest on edge N+1.
- Throughput: one byte per cycle while parsing. Each token costs one extra cycle minimum in OUT.
- out_valid, out_data and out_err are registered. in_ready is decoded from state only, with no combinational path from out_ready.
- While out_valid is high and out_ready is low, outputs hold indefinitely and no input is consumed.

## Configuration
- SIGNED_EN defined:
  - '-' in SKIP enters SIGN.
  - On termination, out_data←neg ? −acc : acc (two's complement).
  - For neg=0: err = ovf | (acc > 2^31−1).
  - For neg=1: err = ovf | (acc > 2^31).
  - For neg=1 with acc=2^31, the result is 0x80000000 with err=0.
- SIGNED_EN undefined:
  - The SIGN state and neg register are absent.
  - '-' is an invalid byte.
  - Results are unsigned 0..2^32−1.

## Test plan
- "  123\n" (0x20,0x20,0x31,0x32,0x33,0x0A) with out_ready=1 → one result 0x0000007B, err=0. out_valid is high exactly one cycle after 0x0A is accepted.
- Unsigned build, "4294967295 " → 0xFFFFFFFF err=0. Then "4294967296 " → 0x00000000 err=1, and "99999999999 " → err=1.
- SIGNED_EN build:
  - "-2147483648 " → 0x80000000 err=0.
  - "-2147483649 " → err=1.
  - "2147483648 " → err=1.
  - "-x" → 0x00000000 err=1, with 'x' consumed.
- Backpressure: "7 8 " with out_ready low for 5 cycles after the first result. out_valid stays high, out_data=7 is held, and in_ready=0 throughout. On release, the second token yields 8.
- Invalid start "a5 " → result 0 err=1 for 'a', then result 5 err=0.
- rstn pulsed low mid-token after "12", then "3 " → result 3 err=0. All outputs at reset values during the reset pulse.
